// File: rtl/main_memory.sv
// Line-granular backing store for a cache hierarchy: fixed-latency line reads
// through a {valid, line address} shift pipeline, zero-latency line writebacks,
// and same-cycle write-to-response forwarding.

`ifndef CACHE_LINE_SIZE
`define CACHE_LINE_SIZE 128
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef OFFSET_SIZE
`define OFFSET_SIZE 4
`endif

module main_memory #(
  parameter int LINE_SIZE   = `CACHE_LINE_SIZE,
  parameter int WORD_SIZE   = `WORD_SIZE,
  parameter int OFFSET_SIZE = `OFFSET_SIZE,
  parameter int MEM_LINES   = 4096,
  parameter int LATENCY     = 5,
  parameter int INIT        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_req,
  input  logic [WORD_SIZE-1:0] mem_req_addr,
  output logic                 mem_res,
  output logic [WORD_SIZE-1:0] mem_res_addr,
  output logic [LINE_SIZE-1:0] mem_res_data,
  input  logic                 mem_write,
  input  logic [WORD_SIZE-1:0] mem_write_addr,
  input  logic [LINE_SIZE-1:0] mem_write_data
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int TAG_W = WORD_SIZE - OFFSET_SIZE;
  localparam int WORDS = LINE_SIZE / 32;

  typedef logic [LINE_SIZE-1:0] mem_t [MEM_LINES];

  // Power-up image: zeros, or every 32-bit word holding its own byte address.
  function automatic mem_t init_contents();
    mem_t m;
    for (int i = 0; i < MEM_LINES; i++) begin
      m[i] = '0;
      if (INIT == 1) begin
        for (int j = 0; j < WORDS; j++) begin
          m[i][j*32 +: 32] = 32'((i << OFFSET_SIZE) + 4 * j);
        end
      end
    end
    return m;
  endfunction

  // Storage is loaded once at time zero; reset never touches it.
  mem_t mem_q = init_contents();

  // Request pipeline: stage k holds a request issued k cycles earlier.
  logic [LATENCY:1] vld_q, vld_d;
  logic [TAG_W-1:0] line_q [1:LATENCY];
  logic [TAG_W-1:0] line_d [1:LATENCY];

  // Registered read of the line that will be answered next cycle, plus a
  // bypass capturing a writeback that lands on that line at the same edge.
  logic [LINE_SIZE-1:0] rd_raw_q;
  logic                 byp_hit_q, byp_hit_d;
  logic [LINE_SIZE-1:0] byp_data_q;

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] res_idx;
  logic             wr_en;
  logic             res_fwd;
  logic [LINE_SIZE-1:0] stored_data;

  // Writebacks presented alongside reset are discarded.
  assign wr_en   = mem_write & ~rst;
  assign wr_idx  = mem_write_addr[OFFSET_SIZE +: IDX_W];
  assign rd_idx  = line_q[LATENCY-1][IDX_W-1:0];
  assign res_idx = line_q[LATENCY][IDX_W-1:0];

  // Next-state of the shift pipeline; a new request enters stage 1.
  always_comb begin
    vld_d     = '0;
    vld_d[1]  = mem_req;
    line_d[1] = mem_req_addr[WORD_SIZE-1:OFFSET_SIZE];
    for (int k = 2; k <= LATENCY; k++) begin
      vld_d[k]  = vld_q[k-1];
      line_d[k] = line_q[k-1];
    end
    byp_hit_d = wr_en && (wr_idx == rd_idx);
  end

  // Pipeline advance; reset flushes every in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
    line_q <= line_d;
  end

  // Line storage: write port plus read-first registered read port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= mem_write_data;
    end
    rd_raw_q <= mem_q[rd_idx];
  end

  // Capture a writeback that collides with the line being read this edge.
  always_ff @(posedge clk) begin
    byp_hit_q  <= byp_hit_d;
    byp_data_q <= mem_write_data;
  end

  // Response: zeroed when idle, forwarded when a writeback hits the same line now.
  always_comb begin
    stored_data  = byp_hit_q ? byp_data_q : rd_raw_q;
    res_fwd      = wr_en && (wr_idx == res_idx);
    mem_res      = vld_q[LATENCY];
    mem_res_addr = '0;
    mem_res_data = '0;
    if (vld_q[LATENCY]) begin
      mem_res_addr = {line_q[LATENCY], {OFFSET_SIZE{1'b0}}};
      mem_res_data = res_fwd ? mem_write_data : stored_data;
    end
  end

  // Address bits outside the line index are intentionally ignored for writes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_write_addr[WORD_SIZE-1:OFFSET_SIZE+IDX_W],
                              mem_write_addr[OFFSET_SIZE-1:0],
                              mem_req_addr[OFFSET_SIZE-1:0]};

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: the driver queues expected responses at
// issue time, a negedge monitor pops and checks them against a line-array model.

module tb_main_memory;

  localparam int LAT   = 5;
  localparam int LINES = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req = 1'b0;
  logic [31:0]  mem_req_addr = '0;
  logic         mem_res;
  logic [31:0]  mem_res_addr;
  logic [127:0] mem_res_data;
  logic         mem_write = 1'b0;
  logic [31:0]  mem_write_addr = '0;
  logic [127:0] mem_write_data = '0;

  always #5 clk = ~clk;

  main_memory #(
    .LINE_SIZE(128), .WORD_SIZE(32), .OFFSET_SIZE(4),
    .MEM_LINES(LINES), .LATENCY(LAT), .INIT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_req_addr(mem_req_addr),
    .mem_res(mem_res), .mem_res_addr(mem_res_addr), .mem_res_data(mem_res_data),
    .mem_write(mem_write), .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data)
  );

  typedef struct {
    int           due;
    logic [31:0]  addr;
    bit           has_lit;
    logic [127:0] lit;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [LINES];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int idx(input logic [31:0] a);
    return int'(a[15:4]);
  endfunction

  // Monitor: one verdict per cycle, model memory updated after the check.
  initial begin
    for (int i = 0; i < LINES; i++)
      for (int j = 0; j < 4; j++)
        model[i][j*32 +: 32] = 32'(i * 16 + 4 * j);
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        bit           exp_v;
        exp_t         e;
        logic [127:0] ed;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        checks++;
        if (mem_res !== exp_v) begin
          failures++;
          $display("FAIL res_valid cyc=%0d got=%b want=%b", cyc, mem_res, exp_v);
        end
        if (exp_v) begin
          e = sb.pop_front();
          ed = (mem_write && !rst && idx(mem_write_addr) == idx(e.addr))
               ? mem_write_data : model[idx(e.addr)];
          $display("resp cyc=%0d addr=%h data=%h", cyc, mem_res_addr, mem_res_data);
          checks++;
          if (mem_res_addr !== e.addr) begin
            failures++;
            $display("FAIL res_addr cyc=%0d got=%h want=%h", cyc, mem_res_addr, e.addr);
          end
          checks++;
          if (mem_res_data !== ed) begin
            failures++;
            $display("FAIL res_data cyc=%0d got=%h want=%h", cyc, mem_res_data, ed);
          end
          if (e.has_lit) begin
            checks++;
            if (mem_res_data !== e.lit) begin
              failures++;
              $display("FAIL directed_data cyc=%0d got=%h want=%h", cyc, mem_res_data, e.lit);
            end
          end
        end else begin
          checks++;
          if (mem_res_addr !== 32'h0 || mem_res_data !== 128'h0) begin
            failures++;
            $display("FAIL idle_zero cyc=%0d addr=%h data=%h want zeros", cyc, mem_res_addr, mem_res_data);
          end
        end
        if (mem_write && !rst) model[idx(mem_write_addr)] = mem_write_data;
      end
    end
  end

  // Drive one cycle of stimulus and record what the memory owes in return.
  task automatic step(input bit r, input logic [31:0] ra, input bit w,
                      input logic [31:0] wa, input logic [127:0] wd, input bit rs,
                      input bit lit_en = 1'b0, input logic [127:0] lit = '0);
    exp_t e;
    exp_t keep[$];
    @(posedge clk);
    #1;
    rst            = rs;
    mem_req        = r;
    mem_req_addr   = ra;
    mem_write      = w;
    mem_write_addr = wa;
    mem_write_data = wd;
    if (rs) begin
      foreach (sb[i]) if (sb[i].due <= cyc) keep.push_back(sb[i]);
      sb = keep;
    end else if (r) begin
      e.due     = cyc + LAT;
      e.addr    = {ra[31:4], 4'h0};
      e.has_lit = lit_en;
      e.lit     = lit;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    logic [127:0] d;
    step(0, '0, 0, '0, '0, 1);
    step(0, '0, 0, '0, '0, 1);

    // Word-address initial image, low offset bits ignored
    step(1, 32'h0000_0104, 0, '0, '0, 0, 1, 128'h0000010C_00000108_00000104_00000100);
    idle(LAT + 1);

    // Back-to-back requests return in order
    step(1, 32'h000, 0, '0, '0, 0);
    step(1, 32'h010, 0, '0, '0, 0);
    step(1, 32'h020, 0, '0, '0, 0);
    idle(LAT);

    // Writeback after the request is visible at response time
    step(1, 32'h040, 0, '0, '0, 0, 1, {16{8'hA5}});
    step(0, '0, 1, 32'h040, {16{8'hA5}}, 0);
    idle(LAT);

    // Writeback in the response cycle is forwarded
    step(1, 32'h080, 0, '0, '0, 0, 1, {4{32'hDEAD_BEEF}});
    idle(LAT - 1);
    step(0, '0, 1, 32'h080, {4{32'hDEAD_BEEF}}, 0);
    idle(LAT);

    // Reset drops in-flight request, writeback under reset ignored
    step(1, 32'h200, 0, '0, '0, 0);
    idle(1);
    step(1, 32'h200, 1, 32'h200, {4{32'h0BAD_0BAD}}, 1);
    idle(8);
    step(1, 32'h200, 0, '0, '0, 0, 1, 128'h0000020C_00000208_00000204_00000200);
    idle(LAT);

    // High address bits alias onto the same line
    d = {$urandom, $urandom, $urandom, $urandom};
    step(0, '0, 1, 32'h0000_0000, d, 0);
    step(1, 32'h0001_0000, 0, '0, '0, 0, 1, d);
    idle(LAT);

    // Duplicate requests each answered; request and write in one cycle
    d = {$urandom, $urandom, $urandom, $urandom};
    step(1, 32'h300, 0, '0, '0, 0);
    step(1, 32'h308, 1, 32'h300, d, 0, 1, d);
    step(1, 32'h304, 1, 32'h310, ~d, 0, 1, d);
    idle(LAT);

    // Randomized traffic over a few lines with aliasing and occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, wa;
      ra = (32'($urandom_range(0, 15)) << 16) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      wa = (32'($urandom_range(0, 15)) << 16) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
      d  = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 2) == 0), wa, d,
           ($urandom_range(0, 39) == 0));
    end
    idle(LAT + 2);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
